// File: rtl/gcd_exponent_sequencer_pkg.sv
// Shared types and constants for the exponent-search sequencer.
//   state_e : sequencer FSM states
//   err_t   : completion status codes reported on err_o
package gcd_exponent_sequencer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PHI,
      S_ISSUE,
      S_WAIT,
      S_CHECK,
      S_FIN
   } state_e;

   typedef logic [1:0] err_t;

   localparam err_t ERR_OK        = 2'd0;
   localparam err_t ERR_BAD_INPUT = 2'd1;
   localparam err_t ERR_NO_E      = 2'd2;
   localparam err_t ERR_TIMEOUT   = 2'd3;

endpackage

// File: rtl/gcd_exponent_sequencer_if.sv
// Request/response handshake to the shared GCD engine.
//   gcd_start  : one-cycle request pulse (master -> engine)
//   gcd_a/b    : operands, held stable until gcd_done
//   gcd_done   : result-valid pulse (engine -> master)
//   gcd_result : gcd value, valid with gcd_done
interface gcd_exponent_sequencer_if
   import gcd_exponent_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic                 gcd_start;
   logic [2*WIDTH-1:0]   gcd_a;
   logic [2*WIDTH-1:0]   gcd_b;
   logic                 gcd_done;
   logic [2*WIDTH-1:0]   gcd_result;

   modport master (output gcd_start, gcd_a, gcd_b, input  gcd_done, gcd_result);
   modport slave  (input  gcd_start, gcd_a, gcd_b, output gcd_done, gcd_result);
endinterface

// File: rtl/gcd_exponent_sequencer_timeout_counter.sv
// Per-request watchdog for the GCD engine.
//   clear_i   : reload (issued together with gcd_start)
//   enable_i  : count while waiting for the engine
//   expired_o : high in the last wait cycle, so the completion lands
//               exactly TIMEOUT cycles after gcd_start (TIMEOUT >= 2)
module gcd_exponent_sequencer_timeout_counter #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int             CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]  LOAD = CW'(TIMEOUT - 2);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = LOAD;
      else if (enable_i && (cnt_q != '0))
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= LOAD;
      else     cnt_q <= cnt_d;
   end

   assign expired_o = enable_i && (cnt_q == '0);
endmodule

// File: rtl/gcd_exponent_sequencer.sv
// Key-setup controller: forms phi = (p-1)*(q-1) and walks odd candidates
// e = E_START, E_START+2, ... through the GCD engine until gcd(e, phi) == 1.
//   start_i/p_i/q_i : job request (accepted only in IDLE)
//   busy_o/done_o   : job in progress / one-cycle completion pulse
//   e_out_o/err_o   : found exponent and status, held until next start
//   attempts_o      : engine requests issued for this job (saturating)
//   gcd_if          : master side of the GCD engine handshake
//
// state  | meaning
// IDLE   | waiting for start
// PHI    | compute phi, load first candidate
// ISSUE  | request gcd(e, phi), or give up if e >= phi
// WAIT   | engine busy; watchdog running
// CHECK  | accept e if coprime, else step to e+2
// FIN    | one-cycle done pulse
module gcd_exponent_sequencer
   import gcd_exponent_sequencer_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int E_START = 3,
   parameter int TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      p_i,
   input  logic [WIDTH-1:0]      q_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [2*WIDTH-1:0]    e_out_o,
   output logic [1:0]            err_o,
   output logic [7:0]            attempts_o,
   gcd_exponent_sequencer_if.master gcd_if
);
   localparam int             DW      = 2 * WIDTH;
   localparam logic [DW-1:0]  E_FIRST = DW'(E_START);
   localparam logic [DW:0]    STEP    = (DW+1)'(2);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] p_q, p_d, q_q, q_d;
   logic [DW-1:0]    phi_q, phi_d, e_q, e_d, res_q, res_d, e_out_q, e_out_d;
   err_t             err_q, err_d;
   logic [7:0]       att_q, att_d;

   logic [DW-1:0]    p_m1, q_m1;
   logic [DW:0]      e_plus2;
   logic             issue_ok, gcd_start_c, tmo_clear, tmo_en, tmo_expired;

   assign p_m1     = {{WIDTH{1'b0}}, p_q - WIDTH'(1)};
   assign q_m1     = {{WIDTH{1'b0}}, q_q - WIDTH'(1)};
   // Extra MSB catches the candidate stepping past the operand width.
   assign e_plus2  = {1'b0, e_q} + STEP;
   assign issue_ok = (e_q < phi_q);

   gcd_exponent_sequencer_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (tmo_clear),
      .enable_i  (tmo_en),
      .expired_o (tmo_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         q_q     <= '0;
         phi_q   <= '0;
         e_q     <= '0;
         res_q   <= '0;
         e_out_q <= '0;
         err_q   <= ERR_OK;
         att_q   <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         q_q     <= q_d;
         phi_q   <= phi_d;
         e_q     <= e_d;
         res_q   <= res_d;
         e_out_q <= e_out_d;
         err_q   <= err_d;
         att_q   <= att_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      q_d     = q_q;
      phi_d   = phi_q;
      e_d     = e_q;
      res_d   = res_q;
      e_out_d = e_out_q;
      err_d   = err_q;
      att_d   = att_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               p_d     = p_i;
               q_d     = q_i;
               att_d   = '0;
               err_d   = ERR_OK;
               e_out_d = '0;
               if ((p_i < WIDTH'(2)) || (q_i < WIDTH'(2))) begin
                  err_d   = ERR_BAD_INPUT;
                  state_d = S_FIN;
               end else begin
                  state_d = S_PHI;
               end
            end
         end
         S_PHI: begin
            phi_d   = p_m1 * q_m1;
            e_d     = E_FIRST;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (!issue_ok) begin
               err_d   = ERR_NO_E;
               state_d = S_FIN;
            end else begin
               if (att_q != 8'hFF) att_d = att_q + 8'd1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A result arriving in the expiry cycle still counts.
            if (gcd_if.gcd_done) begin
               res_d   = gcd_if.gcd_result;
               state_d = S_CHECK;
            end else if (tmo_expired) begin
               err_d   = ERR_TIMEOUT;
               state_d = S_FIN;
            end
         end
         S_CHECK: begin
            if (res_q == DW'(1)) begin
               e_out_d = e_q;
               state_d = S_FIN;
            end else if (e_plus2[DW]) begin
               err_d   = ERR_NO_E;
               state_d = S_FIN;
            end else begin
               e_d     = e_plus2[DW-1:0];
               state_d = S_ISSUE;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = 1'b0;
      done_o      = 1'b0;
      gcd_start_c = 1'b0;
      tmo_clear   = 1'b0;
      tmo_en      = 1'b0;
      case (state_q)
         S_PHI, S_CHECK: busy_o = 1'b1;
         S_ISSUE: begin
            busy_o      = 1'b1;
            gcd_start_c = issue_ok;
            tmo_clear   = 1'b1;
         end
         S_WAIT: begin
            busy_o = 1'b1;
            tmo_en = 1'b1;
         end
         S_FIN:   done_o = 1'b1;
         default: ;
      endcase
   end

   // Operands come straight from the candidate/phi registers, which only
   // change in PHI and CHECK, so they are stable from gcd_start to gcd_done.
   assign gcd_if.gcd_start = gcd_start_c;
   assign gcd_if.gcd_a     = e_q;
   assign gcd_if.gcd_b     = phi_q;

   assign e_out_o    = e_out_q;
   assign err_o      = err_q;
   assign attempts_o = att_q;
endmodule
